// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit-side blocks.
//   sched_state_t    : state encoding of the transmit scheduler FSM
//   UART_BAUD_CYCLES : clock cycles per serial bit
//   UART_FRAME_BITS  : bits per frame (start + 8 data + parity + stop)
//   UART_FRAME_CYCLES: cycles for one complete frame; lower bound for the
//                      scheduler's transmitter watchdog
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    localparam int UART_BAUD_CYCLES  = 5208;
    localparam int UART_FRAME_BITS   = 11;
    localparam int UART_FRAME_CYCLES = UART_BAUD_CYCLES * UART_FRAME_BITS;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at i_ptr and wraps modulo
// N; the first asserted request wins.
//   i_req       in  N        : request vector
//   i_ptr       in  clog2(N) : highest-priority index for this pick
//   o_grant_oh  out N        : one-hot winner (all zero when no request)
//   o_grant_idx out clog2(N) : winner index (0 when no request)
//   o_any       out 1        : at least one request is asserted
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant_oh,
    output logic [$clog2(N)-1:0] o_grant_idx,
    output logic                 o_any
);

    localparam int IW = $clog2(N);

    // NOTE: every output gets a default before the search so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        o_grant_oh  = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        // Walk from the farthest position back to i_ptr so the nearest hit
        // overwrites the others; this needs no early exit from the loop.
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[(int'(i_ptr) + k) % N]) begin
                o_grant_oh                          = '0;
                o_grant_oh[(int'(i_ptr) + k) % N]   = 1'b1;
                o_grant_idx                         = IW'((int'(i_ptr) + k) % N);
                o_any                               = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Shares one UART transmitter between NUM_REQ byte sources. Grants one source
// at a time in round-robin order, drives the transmitter's Send/Din and walks
// the Send/Sent four-phase handshake. A watchdog flags a transmitter that
// does not finish within TIMEOUT_CYCLES of the grant.
//   clk         in  1           : system clock
//   CPU_RESETN  in  1           : asynchronous active-low reset
//   req_valid   in  NUM_REQ     : source i holds a byte until req_ready[i]
//   req_data    in  8*NUM_REQ   : byte of source i at [8i+7:8i]
//   req_ready   out NUM_REQ     : one-cycle pulse, byte of source i accepted
//   tx_send     out 1           : to tx.Send
//   tx_din      out 8           : to tx.Din, held for the whole transfer
//   tx_sent     in  1           : from tx.Sent
//   busy        out 1           : a transfer is in progress
//   grant_id    out clog2(N)    : current or last granted source
//   timeout_err out 1           : sticky transmitter-timeout flag
//   clear_err   in  1           : synchronous clear of timeout_err
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                       clk,
    input  logic                       CPU_RESETN,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       tx_send,
    output logic [7:0]                 tx_din,
    input  logic                       tx_sent,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       timeout_err,
    input  logic                       clear_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [IW-1:0]    r_ptr;
    logic [7:0]       r_din;
    logic [IW-1:0]    r_grant;
    logic [NUM_REQ-1:0] r_ready;
    logic             r_send;
    logic             r_busy;
    logic             r_err;
    logic [CW-1:0]    r_cnt;

    logic [NUM_REQ-1:0] w_win_oh;
    logic [IW-1:0]    w_win_idx;
    logic             w_any;
    logic             w_grant_now;
    logic             w_timeout;
    logic             w_cnt_last;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant_oh  (w_win_oh),
        .o_grant_idx (w_win_idx),
        .o_any       (w_any)
    );

    // The counter reads k-1 in the k-th cycle after the grant. Firing one
    // count early makes the error flag visible exactly TIMEOUT_CYCLES cycles
    // after the grant decision, as the counter would reach TIMEOUT_CYCLES-1.
    assign w_cnt_last = (r_cnt == CW'(TIMEOUT_CYCLES - 2));

    always_comb begin
        w_state_nxt = r_state;
        w_grant_now = 1'b0;
        w_timeout   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = SEND;
                    w_grant_now = 1'b1;
                end
            end
            SEND: begin
                if (w_cnt_last) begin
                    w_state_nxt = IDLE;
                    w_timeout   = 1'b1;
                end else if (tx_sent) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (w_cnt_last) begin
                    w_state_nxt = IDLE;
                    w_timeout   = 1'b1;
                end else if (!tx_sent) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // in this block samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_din   <= '0;
            r_grant <= '0;
            r_ready <= '0;
            r_send  <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_send  <= (w_state_nxt == SEND);
            r_busy  <= (w_state_nxt != IDLE);
            r_ready <= w_grant_now ? w_win_oh : '0;

            if (w_grant_now) begin
                r_din   <= req_data[{w_win_idx, 3'b000} +: 8];
                r_grant <= w_win_idx;
                r_ptr   <= (w_win_idx == IW'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;
                r_cnt   <= '0;
            end else if (r_state != IDLE) begin
                r_cnt   <= r_cnt + 1'b1;
            end

            // A timeout in the same cycle as clear_err leaves the flag set.
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (clear_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign req_ready   = r_ready;
    assign tx_send     = r_send;
    assign tx_din      = r_din;
    assign busy        = r_busy;
    assign grant_id    = r_grant;
    assign timeout_err = r_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
// Scoreboard bench: a transaction-level reference decides at each clock edge
// which source should be granted (round-robin over the valid set) and queues
// the expected grant; a monitor pops and compares whenever req_ready pulses.
// A small transmitter model answers tx_send with tx_sent.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

    localparam int N = 4;
    localparam int T = 64;

    logic           clk = 1'b0;
    logic           CPU_RESETN;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx_send;
    logic [7:0]     tx_din;
    logic           tx_sent;
    logic           busy;
    logic [1:0]     grant_id;
    logic           timeout_err;
    logic           clear_err;

    always #5 clk = ~clk;

    uart_tx_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .clk         (clk),
        .CPU_RESETN  (CPU_RESETN),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_send     (tx_send),
        .tx_din      (tx_din),
        .tx_sent     (tx_sent),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err),
        .clear_err   (clear_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         id;
        logic [7:0] data;
    } grant_t;

    grant_t exp_q[$];

    // Control shared from the main sequence (single writer each).
    int         stim_mode = 0;   // 0 directed, 1 random, 2 hold-and-reload once
    logic [N-1:0] pend_mask = '0;
    logic [7:0] pend_byte[N];
    int         pend_id   = 0;
    bit         stall     = 1'b0;
    int         fixed_lat = 0;

    // Written only by the monitor.
    int grants = 0;
    int ready_cnt[N];
    int gid_log[$];

    // ---------------- reference model ----------------
    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    int m_ptr = 0;
    int m_win;
    bit m_seen;

    initial begin : ref_model
        forever begin
            @(posedge clk);
            if (!CPU_RESETN) begin
                m_ptr = 0;
                continue;
            end
            if (req_valid != '0) begin
                m_win = rr_pick(req_valid, m_ptr);
                exp_q.push_back('{m_win, req_data[8*m_win +: 8]});
                m_ptr  = (m_win + 1) % N;
                m_seen = 1'b0;
                // A transfer occupies the scheduler until the handshake
                // completes or T-1 further edges have passed.
                for (int j = 1; j <= T - 1; j++) begin
                    @(posedge clk);
                    if (!CPU_RESETN) begin
                        m_ptr = 0;
                        break;
                    end
                    if (j == T - 1) break;
                    if (!m_seen) m_seen = tx_sent;
                    else if (!tx_sent) break;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    grant_t mon_e;

    initial begin : monitor
        for (int i = 0; i < N; i++) ready_cnt[i] = 0;
        forever begin
            @(negedge clk);
            if (!CPU_RESETN) begin
                exp_q.delete();
                continue;
            end
            if (req_ready != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", req_ready, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("grant_ready_vec", req_ready, 32'(1) << mon_e.id);
                    check("grant_id", grant_id, mon_e.id);
                    check("grant_tx_din", tx_din, mon_e.data);
                    check("grant_tx_send", tx_send, 1);
                    check("grant_busy", busy, 1);
                end
                grants++;
                if (stim_mode == 2) begin
                    gid_log.push_back(int'(grant_id));
                    for (int i = 0; i < N; i++) if (req_ready[i]) ready_cnt[i]++;
                end
            end else if (exp_q.size() != 0) begin
                check("missed_grant", req_ready, 32'(1) << exp_q[0].id);
                void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- requester driver ----------------
    int drv_done = 0;
    int drv_reloads[N];

    initial begin : requesters
        req_valid = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) drv_reloads[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    if (stim_mode == 2 && drv_reloads[i] == 0) begin
                        drv_reloads[i] = 1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            if (pend_id != drv_done) begin
                drv_done = pend_id;
                for (int i = 0; i < N; i++) begin
                    if (pend_mask[i]) begin
                        req_valid[i]       = 1'b1;
                        req_data[8*i +: 8] = pend_byte[i];
                        drv_reloads[i]     = 0;
                    end
                end
            end
            if (stim_mode == 1) begin
                for (int i = 0; i < N; i++) begin
                    if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                        req_valid[i]       = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end
            end
        end
    end

    // ---------------- transmitter model ----------------
    int tx_lat;

    initial begin : tx_model
        tx_sent = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_send && CPU_RESETN) begin
                tx_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 20));
                if (!stall) begin
                    repeat (tx_lat - 1) @(negedge clk);
                    if (tx_send) tx_sent = 1'b1;
                end
                for (int k = 0; k < 200 && tx_send; k++) @(negedge clk);
                check("tx_send_released", tx_send, 0);
                repeat ($urandom_range(0, 8)) @(negedge clk);
                tx_sent = 1'b0;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic request(input logic [N-1:0] mask, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
        pend_byte[0] = b0;
        pend_byte[1] = b1;
        pend_byte[2] = b2;
        pend_byte[3] = b3;
        pend_mask    = mask;
        pend_id++;
    endtask

    task automatic wait_ready(input string name);
        int k;
        for (k = 0; k < 300; k++) begin
            tick();
            if (req_ready != '0) break;
        end
        check({name, "_ready_seen"}, (k < 300), 1);
    endtask

    task automatic wait_idle(input string name);
        int k;
        int quiet;
        quiet = 0;
        for (k = 0; k < 3000 && quiet < 12; k++) begin
            tick();
            if (req_valid == '0 && !busy && !tx_sent) quiet++;
            else quiet = 0;
        end
        check({name, "_drained"}, (quiet >= 12), 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_tx_send"}, tx_send, 0);
        check({name, "_tx_din"}, tx_din, 0);
        check({name, "_req_ready"}, req_ready, 0);
        check({name, "_busy"}, busy, 0);
        check({name, "_grant_id"}, grant_id, 0);
        check({name, "_timeout_err"}, timeout_err, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int k;
        int start;
        CPU_RESETN = 1'b0;
        clear_err  = 1'b0;
        #3;
        check_reset_outputs("por");
        repeat (3) @(negedge clk);
        CPU_RESETN = 1'b1;
        repeat (2) tick();

        // Single request from source 2, slow transmitter.
        fixed_lat = 40;
        request(4'b0100, 8'h00, 8'h00, 8'h41, 8'h00);
        wait_ready("single");
        check("single_req_ready", req_ready, 4'b0100);
        check("single_tx_din", tx_din, 8'h41);
        check("single_grant_id", grant_id, 2);
        tick();
        check("single_ready_one_cycle", req_ready, 0);
        for (k = 0; k < 200 && !tx_sent; k++) tick();
        check("single_sent_seen", tx_sent, 1);
        check("single_send_high_at_sent", tx_send, 1);
        tick();
        check("single_send_falls", tx_send, 0);
        check("single_busy_in_done", busy, 1);
        for (k = 0; k < 200 && tx_sent; k++) tick();
        check("single_sent_drop_seen", tx_sent, 0);
        check("single_busy_before_drop_seen", busy, 1);
        tick();
        check("single_busy_falls", busy, 0);
        fixed_lat = 0;
        wait_idle("single");

        // Pointer now 3: only source 1 valid -> wraps to 1, pointer becomes 2.
        request(4'b0010, 8'h00, 8'h3C, 8'h00, 8'h00);
        wait_ready("wrap");
        check("wrap_grant", grant_id, 1);
        wait_idle("wrap");
        request(4'b0110, 8'h00, 8'h11, 8'h22, 8'h00);
        wait_ready("wrap_ptr");
        check("wrap_ptr_is_2", grant_id, 2);
        wait_idle("wrap_ptr");

        // Timeout: transmitter never answers.
        stall = 1'b1;
        request(4'b0001, 8'h99, 8'h00, 8'h00, 8'h00);
        wait_ready("timeout");
        repeat (T - 2) tick();
        check("timeout_err_before", timeout_err, 0);
        check("timeout_busy_before", busy, 1);
        tick();
        check("timeout_err_set", timeout_err, 1);
        check("timeout_send_low", tx_send, 0);
        check("timeout_idle", busy, 0);
        tick();
        check("timeout_err_sticky", timeout_err, 1);
        clear_err = 1'b1;
        tick();
        check("timeout_err_cleared", timeout_err, 0);

        // clear_err held across a second timeout: setting wins.
        request(4'b0010, 8'h00, 8'h77, 8'h00, 8'h00);
        wait_ready("timeout2");
        repeat (T - 2) tick();
        check("timeout2_err_before", timeout_err, 0);
        tick();
        check("timeout2_set_wins", timeout_err, 1);
        tick();
        check("timeout2_clear_after", timeout_err, 0);
        clear_err = 1'b0;
        stall     = 1'b0;
        wait_idle("timeout2");

        // Randomised traffic.
        start     = grants;
        stim_mode = 1;
        for (k = 0; k < 20000 && (grants - start) < 40; k++) tick();
        check("random_progress", ((grants - start) >= 40), 1);
        stim_mode = 0;
        wait_idle("random");

        // Reset asserted mid-transfer, between clock edges.
        fixed_lat = 15;
        request(4'b1000, 8'h00, 8'h00, 8'h00, 8'hA5);
        wait_ready("midreset");
        repeat (3) tick();
        #1;
        CPU_RESETN = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        CPU_RESETN = 1'b1;
        fixed_lat  = 0;
        repeat (30) tick();

        // Fairness: all sources hold valid, each reloads once -> 8 grants.
        stim_mode = 2;
        request(4'b1111, 8'h10, 8'h20, 8'h30, 8'h40);
        for (k = 0; k < 3000 && gid_log.size() < 8; k++) tick();
        check("fair_count", gid_log.size(), 8);
        for (int i = 0; i < gid_log.size() && i < 8; i++) check("fair_order", gid_log[i], i % N);
        for (int i = 0; i < N; i++) check("fair_ready_twice", ready_cnt[i], 2);
        wait_idle("fair");
        stim_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
